// File: rtl/mem_stage.sv
// Memory-access pipeline stage: load byte/half extraction, SRAM read-data hold
// across writeback stalls, forwarding/hazard info and the memory->writeback bus.
module mem_stage #(
  parameter int EXE_TO_MEM_BUS_WD = 160,
  parameter int MEM_TO_WB_BUS_WD  = 152
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         exe_to_mem_valid,
  input  logic [EXE_TO_MEM_BUS_WD-1:0] exe_to_mem_bus,
  output logic                         mem_allowin,
  input  logic [31:0]                  data_sram_rdata,
  input  logic                         wb_allowin,
  input  logic                         wb_ex,
  output logic                         mem_to_wb_valid,
  output logic [MEM_TO_WB_BUS_WD-1:0]  mem_to_wb_bus,
  output logic                         gr_we_mem,
  output logic [4:0]                   dest_mem,
  output logic [31:0]                  forward_data_mem,
  output logic                         mem_csr_re,
  output logic                         mem_ex
);

  typedef enum logic {LIVE = 1'b0, HELD = 1'b1} hold_state_t;

  logic                         mem_valid_reg;
  logic [EXE_TO_MEM_BUS_WD-1:0] bus_reg;
  hold_state_t                  hold_state_reg, hold_state_next;
  logic [31:0]                  rdata_buf_reg, rdata_buf_next;

  logic        capture;
  logic [81:0] csr_to_ertn;
  logic        ld_b, ld_bu, ld_h, ld_hu, load_op, gr_we;
  logic [4:0]  dest;
  logic [31:0] alu_result, pc;
  logic [31:0] rdata_eff, load_data, final_result;
  logic [7:0]  byte_lane [4];
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic        unused_fields;

  // ready_go is always 1: the stage only waits on writeback
  assign mem_allowin     = ~mem_valid_reg | (wb_allowin & ~wb_ex);
  assign mem_to_wb_valid = mem_valid_reg & ~wb_ex;
  assign capture         = exe_to_mem_valid & mem_allowin & ~wb_ex;

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_valid_reg <= 1'b0;
      bus_reg       <= '0;
    end else begin
      if (wb_ex)
        mem_valid_reg <= 1'b0;
      else if (mem_allowin)
        mem_valid_reg <= exe_to_mem_valid;
      if (capture)
        bus_reg <= exe_to_mem_bus;
    end
  end

  // The SRAM only presents read data for one cycle, so grab it on the first stall cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_state_reg <= LIVE;
      rdata_buf_reg  <= '0;
    end else begin
      hold_state_reg <= hold_state_next;
      rdata_buf_reg  <= rdata_buf_next;
    end
  end

  always_comb begin
    hold_state_next = hold_state_reg;
    rdata_buf_next  = rdata_buf_reg;
    case (hold_state_reg)
      LIVE: begin
        if (capture) begin
          hold_state_next = LIVE;
        end else if (mem_valid_reg && !wb_allowin) begin
          hold_state_next = HELD;
          rdata_buf_next  = data_sram_rdata;
        end
      end
      HELD: begin
        if (capture)
          hold_state_next = LIVE;
      end
      default: hold_state_next = LIVE;
    endcase
  end

  assign rdata_eff = (hold_state_reg == HELD) ? rdata_buf_reg : data_sram_rdata;

  assign csr_to_ertn = bus_reg[159:78];
  assign ld_b        = bus_reg[77];
  assign ld_bu       = bus_reg[76];
  assign ld_h        = bus_reg[75];
  assign ld_hu       = bus_reg[74];
  assign load_op     = bus_reg[70];
  assign gr_we       = bus_reg[69];
  assign dest        = bus_reg[68:64];
  assign alu_result  = bus_reg[63:32];
  assign pc          = bus_reg[31:0];
  // ld_w and the no-flag load both return the full word; signed/lu12i are not needed here
  assign unused_fields = ^bus_reg[73:71];

  for (genvar gi = 0; gi < 4; gi++) begin : g_byte_lane
    assign byte_lane[gi] = rdata_eff[8*gi +: 8];
  end

  assign load_byte = byte_lane[alu_result[1:0]];
  assign load_half = alu_result[1] ? rdata_eff[31:16] : rdata_eff[15:0];

  always_comb begin
    load_data = rdata_eff;
    if (ld_b)
      load_data = {{24{load_byte[7]}}, load_byte};
    else if (ld_bu)
      load_data = {24'h0, load_byte};
    else if (ld_h)
      load_data = {{16{load_half[15]}}, load_half};
    else if (ld_hu)
      load_data = {16'h0, load_half};
  end

  assign final_result = load_op ? load_data : alu_result;

  assign mem_to_wb_bus    = mem_valid_reg ? {csr_to_ertn, gr_we, dest, final_result, pc} : '0;
  assign gr_we_mem        = mem_valid_reg & gr_we;
  assign dest_mem         = mem_valid_reg ? dest : 5'd0;
  assign forward_data_mem = mem_valid_reg ? final_result : 32'd0;
  assign mem_csr_re       = mem_valid_reg & bus_reg[159];
  assign mem_ex           = mem_valid_reg & bus_reg[79];

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboarded bench for mem_stage: directed scenarios followed by random traffic,
// checked against a behavioural model of stage occupancy and load extraction.
module tb_mem_stage;

  logic         clk = 1'b0;
  logic         reset;
  logic         exe_to_mem_valid;
  logic [159:0] exe_to_mem_bus;
  logic         mem_allowin;
  logic [31:0]  data_sram_rdata;
  logic         wb_allowin;
  logic         wb_ex;
  logic         mem_to_wb_valid;
  logic [151:0] mem_to_wb_bus;
  logic         gr_we_mem;
  logic [4:0]   dest_mem;
  logic [31:0]  forward_data_mem;
  logic         mem_csr_re;
  logic         mem_ex;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .reset(reset),
    .exe_to_mem_valid(exe_to_mem_valid), .exe_to_mem_bus(exe_to_mem_bus),
    .mem_allowin(mem_allowin), .data_sram_rdata(data_sram_rdata),
    .wb_allowin(wb_allowin), .wb_ex(wb_ex),
    .mem_to_wb_valid(mem_to_wb_valid), .mem_to_wb_bus(mem_to_wb_bus),
    .gr_we_mem(gr_we_mem), .dest_mem(dest_mem), .forward_data_mem(forward_data_mem),
    .mem_csr_re(mem_csr_re), .mem_ex(mem_ex)
  );

  // exp_q holds the expected writeback bus of the instruction occupying the stage
  logic [151:0] exp_q [$];
  int           checks   = 0;
  int           failures = 0;
  bit           mon_en   = 1'b0;
  bit           first_cycle = 1'b0;
  logic [31:0]  planned_rd = 32'h0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [31:0] ref_load(input int kind, input logic [1:0] a, input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(rd >> (8 * a));
    h = 16'(rd >> (16 * a[1]));
    case (kind)
      0: return {{24{b[7]}}, b};
      1: return {24'h0, b};
      2: return {{16{h[15]}}, h};
      3: return {16'h0, h};
      default: return rd;
    endcase
  endfunction

  function automatic logic [151:0] expected_bus(input logic [159:0] b, input logic [31:0] rd);
    int          kind;
    logic [31:0] res;
    if (b[77])      kind = 0;
    else if (b[76]) kind = 1;
    else if (b[75]) kind = 2;
    else if (b[74]) kind = 3;
    else            kind = 4;
    res = b[70] ? ref_load(kind, b[33:32], rd) : b[63:32];
    return {b[159:78], b[69], b[68:64], res, b[31:0]};
  endfunction

  // kind: 0 ld_b, 1 ld_bu, 2 ld_h, 3 ld_hu, 4 ld_w, 5 load_op without flags, 6 non-load
  function automatic logic [159:0] make_inst(input int kind, input logic [31:0] alu,
                                             input logic [4:0] dest, input logic gr_we,
                                             input logic syscall, input logic csr_re);
    logic [159:0] b;
    b = {$urandom, $urandom, $urandom, $urandom, $urandom};
    b[77:73] = 5'b0;
    case (kind)
      0: b[77] = 1'b1;
      1: b[76] = 1'b1;
      2: b[75] = 1'b1;
      3: b[74] = 1'b1;
      4: b[73] = 1'b1;
      default: ;
    endcase
    b[70]    = (kind <= 5);
    b[69]    = gr_we;
    b[68:64] = dest;
    b[63:32] = alu;
    b[79]    = syscall;
    b[159]   = csr_re;
    return b;
  endfunction

  // One clock cycle of stimulus; the model update lands after the monitor has sampled.
  task automatic step(input logic rs, input logic ev, input logic [159:0] bus, input logic wa,
                      input logic wx, input logic [31:0] rd_plan, input logic [31:0] rd_other);
    bit occ, accept, flushed;
    @(posedge clk); #1;
    occ = (exp_q.size() != 0);
    reset            = rs;
    exe_to_mem_valid = ev;
    exe_to_mem_bus   = bus;
    wb_allowin       = wa;
    wb_ex            = wx;
    data_sram_rdata  = first_cycle ? planned_rd : rd_other;
    accept  = !rs && ev && !wx && (!occ || wa);
    flushed = occ && wx;
    @(negedge clk); #1;
    if (rs || flushed) exp_q.delete();
    first_cycle = accept;
    if (accept) begin
      planned_rd = rd_plan;
      exp_q.push_back(expected_bus(bus, rd_plan));
    end
  endtask

  task automatic idle(input logic wa);
    step(1'b0, 1'b0, 160'h0, wa, 1'b0, 32'h0, $urandom);
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (mon_en) begin
        bit           occ, exp_v;
        logic [151:0] front;
        occ   = (exp_q.size() != 0);
        front = occ ? exp_q[0] : 152'h0;
        exp_v = occ && !wb_ex;
        check("valid",   mem_to_wb_valid, exp_v);
        check("allowin", mem_allowin, !occ || (wb_allowin && !wb_ex));
        check("bus",     mem_to_wb_bus, front);
        check("gr_we",   gr_we_mem, front[69]);
        check("dest",    dest_mem, front[68:64]);
        check("fwd",     forward_data_mem, front[63:32]);
        check("csr_re",  mem_csr_re, front[151]);
        check("ex",      mem_ex, front[71]);
        if (exp_v && wb_allowin) begin
          $display("WB pc=%h dest=%0d we=%0d result=%h", front[31:0], front[68:64], front[69], front[63:32]);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin : stimulus
    reset = 1'b1; exe_to_mem_valid = 1'b0; exe_to_mem_bus = '0;
    wb_allowin = 1'b0; wb_ex = 1'b0; data_sram_rdata = '0;
    repeat (2) @(posedge clk);
    #1 mon_en = 1'b1;
    step(1'b1, 1'b0, 160'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    idle(1'b1);
    check("reset_allowin", mem_allowin, 1'b1);
    check("reset_valid", mem_to_wb_valid, 1'b0);

    // byte loads at offset 3
    step(0, 1, make_inst(0, 32'h1003, 5'd1, 1, 0, 0), 1, 0, 32'h80FF1234, $urandom);
    step(0, 1, make_inst(1, 32'h1003, 5'd2, 1, 0, 0), 1, 0, 32'h80FF1234, $urandom);
    check("t1_ld_b", forward_data_mem, 32'hFFFFFF80);
    idle(1'b1);
    check("t1_ld_bu", forward_data_mem, 32'h00000080);

    // half loads
    step(0, 1, make_inst(2, 32'h2002, 5'd3, 1, 0, 0), 1, 0, 32'h9ABC5678, $urandom);
    step(0, 1, make_inst(3, 32'h2000, 5'd4, 1, 0, 0), 1, 0, 32'h9ABC5678, $urandom);
    check("t2_ld_h", forward_data_mem, 32'hFFFF9ABC);
    idle(1'b1);
    check("t2_ld_hu", forward_data_mem, 32'h00005678);

    // ld_w stalled for 3 cycles while SRAM data changes
    step(0, 1, make_inst(4, 32'h3000, 5'd7, 1, 0, 0), 1, 0, 32'h13579BDF, 32'hDEADBEEF);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 160'h0, 0, 0, 32'h0, 32'hDEADBEEF);
      check("t3_stall_allowin", mem_allowin, 1'b0);
    end
    step(0, 0, 160'h0, 1, 0, 32'h0, 32'hDEADBEEF);
    check("t3_release_fwd", forward_data_mem, 32'h13579BDF);
    check("t3_release_valid", mem_to_wb_valid, 1'b1);

    // back-to-back add then ld_w
    idle(1'b1);
    step(0, 1, make_inst(6, 32'h11, 5'd5, 1, 0, 0), 1, 0, 32'h0, $urandom);
    step(0, 1, make_inst(4, 32'h4000, 5'd6, 1, 0, 0), 1, 0, 32'hCAFEF00D, $urandom);
    check("t4_dest_add", dest_mem, 5'd5);
    check("t4_fwd_add", forward_data_mem, 32'h11);
    check("t4_valid_add", mem_to_wb_valid, 1'b1);
    idle(1'b1);
    check("t4_dest_ld", dest_mem, 5'd6);
    check("t4_fwd_ld", forward_data_mem, 32'hCAFEF00D);
    check("t4_valid_ld", mem_to_wb_valid, 1'b1);

    // syscall flushed by wb_ex with a concurrent incoming inst
    step(0, 1, make_inst(6, 32'h55, 5'd8, 1, 1, 0), 1, 0, 32'h0, $urandom);
    idle(1'b0);
    check("t5_ex_before", mem_ex, 1'b1);
    step(0, 1, make_inst(6, 32'h66, 5'd9, 1, 0, 0), 0, 1, 32'h0, $urandom);
    check("t5_valid_pulse", mem_to_wb_valid, 1'b0);
    idle(1'b1);
    check("t5_ex_after", mem_ex, 1'b0);
    check("t5_valid_after", mem_to_wb_valid, 1'b0);
    check("t5_dest_after", dest_mem, 5'd0);

    // reset in the middle of a held stall
    step(0, 1, make_inst(4, 32'h5000, 5'd10, 1, 0, 1), 1, 0, 32'h2468ACE0, $urandom);
    idle(1'b0);
    idle(1'b0);
    step(1, 0, 160'h0, 0, 0, 32'h0, $urandom);
    idle(1'b1);
    check("t6_fwd", forward_data_mem, 32'h0);
    check("t6_dest", dest_mem, 5'd0);
    check("t6_allowin", mem_allowin, 1'b1);
    check("t6_csr_re", mem_csr_re, 1'b0);
    step(0, 1, make_inst(4, 32'h6000, 5'd11, 1, 0, 0), 1, 0, 32'h0F0F1234, $urandom);
    idle(1'b1);
    check("t6_post_reset_ld", forward_data_mem, 32'h0F0F1234);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      logic rs, ev, wa, wx;
      rs = ($urandom_range(0, 99) == 0);
      ev = ($urandom_range(0, 3) != 0);
      wa = ($urandom_range(0, 3) != 0);
      wx = ($urandom_range(0, 19) == 0);
      if (rs) begin ev = 1'b0; wa = 1'b0; wx = 1'b0; end
      step(rs, ev,
           make_inst(int'($urandom_range(0, 6)), $urandom, 5'($urandom), 1'($urandom),
                     ($urandom_range(0, 7) == 0), 1'($urandom)),
           wa, wx, $urandom, $urandom);
    end

    for (int n = 0; n < 10 && exp_q.size() != 0; n++) idle(1'b1);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d required=0 entries left", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
